stoch_decorr_array: RTL and testbench

STOCH_DECORR_ARRAY -- requirements
Module: stoch_decorr_array

---
 rtl/stoch_decorr_array_pkg.sv | 23 ++
 rtl/fibonacci_lfsr_64.sv | 25 ++
 rtl/stoch_decorr_lane.sv | 71 +++++++
 rtl/stoch_decorr_array.sv | 63 ++++++
 tb/tb_stoch_decorr_array.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/stoch_decorr_array_pkg.sv
// Shared limits, constants and helpers for the stochastic decorrelation array.
// No logic of its own; imported by the lane and top modules.
// Lane i takes its random slice from the shared LFSR rotated by ROT_STEP*i bits.
package stoch_decorr_array_pkg;

    localparam int MIN_CH       = 1;
    localparam int MAX_CH       = 8;
    localparam int MIN_CNT_BITS = 4;
    localparam int MAX_CNT_BITS = 16;
    localparam int LFSR_BITS    = 64;
    localparam int ROT_STEP     = 7;

    // Lowest bit of lane's counter slice inside the packed level bus.
    function automatic int level_lsb(input int lane, input int cnt_bits);
        return lane * cnt_bits;
    endfunction

    // Left-rotation amount applied to the LFSR word for a given lane.
    function automatic int rot_amt(input int lane);
        return (ROT_STEP * lane) % LFSR_BITS;
    endfunction

endpackage

// File: rtl/fibonacci_lfsr_64.sv
// Free-running 64-bit Fibonacci LFSR, taps 64/63/61/60 (maximal length).
// One new bit per CLK edge; synchronous active-low reset loads a fixed non-zero seed.
// No enable and no backpressure: it always advances.
module fibonacci_lfsr_64 (
    input  logic        CLK,
    input  logic        nRST,
    output logic [63:0] r
);

    localparam logic [63:0] SEED = 64'hACE1_2468_1357_BDF9;

    logic feedback;

    assign feedback = r[63] ^ r[62] ^ r[60] ^ r[59];

    // Shift left each edge, feedback bit enters at the bottom.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r <= SEED;
        end else begin
            r <= {r[62:0], feedback};
        end
    end

endmodule

// File: rtl/stoch_decorr_lane.sv
// One decorrelation lane: saturating counter, random-threshold delay line, sticky overflow.
// Output y is the delay-line tail, so a affects y no earlier than DEPTH edges later.
// en=0 freezes all state; clr wins over en and over saturation.
module stoch_decorr_lane
    import stoch_decorr_array_pkg::*;
#(
    parameter int COUNTER_SIZE = 8,
    parameter int STEP_VAL     = 16,
    parameter int DEPTH        = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    a,
    input  logic [COUNTER_SIZE-1:0] rnd,
    output logic                    y,
    output logic [COUNTER_SIZE-1:0] level,
    output logic                    ovf
);

    localparam logic [COUNTER_SIZE:0]   STEP_WIDE = (COUNTER_SIZE+1)'(STEP_VAL);
    localparam logic [COUNTER_SIZE-1:0] STEP_CNT  = COUNTER_SIZE'(STEP_VAL);

    logic [COUNTER_SIZE-1:0] counter;
    logic [COUNTER_SIZE:0]   sum;
    logic [COUNTER_SIZE-1:0] c;
    logic                    sat;
    logic                    shift_in;
    logic [COUNTER_SIZE-1:0] counter_next;
    logic [DEPTH-1:0]        buffer;
    logic [DEPTH-1:0]        buffer_next;

    assign y     = buffer[DEPTH-1];
    assign level = counter;

    // Add the input weight with one extra bit so saturation is visible, then clamp;
    // subtract the weight back out when the tail bit is 1, flooring at zero.
    always_comb begin
        sum          = {1'b0, counter} + (a ? STEP_WIDE : '0);
        sat          = sum[COUNTER_SIZE];
        c            = sat ? '1 : sum[COUNTER_SIZE-1:0];
        shift_in     = (rnd <= counter);
        counter_next = c;
        if (y) begin
            counter_next = (c < STEP_CNT) ? '0 : c - STEP_CNT;
        end
    end

    generate
        if (DEPTH == 1) begin : g_buf_one
            assign buffer_next = shift_in;
        end else begin : g_buf_multi
            assign buffer_next = {buffer[DEPTH-2:0], shift_in};
        end
    endgenerate

    // Lane state: reset and clear zero everything, otherwise advance only when enabled.
    always_ff @(posedge CLK) begin
        if (!nRST || clr) begin
            counter <= '0;
            buffer  <= '0;
            ovf     <= 1'b0;
        end else if (en) begin
            counter <= counter_next;
            buffer  <= buffer_next;
            ovf     <= ovf | sat;
        end
    end

endmodule

// File: rtl/stoch_decorr_array.sv
// NUM_CH independent decorrelation lanes sharing one free-running 64-bit LFSR.
// a->y latency is at least DEPTH edges; no combinational path from a to y.
// No backpressure: en=0 holds lane state, the LFSR keeps running.
module stoch_decorr_array
    import stoch_decorr_array_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int COUNTER_SIZE = 8,
    parameter int STEP_VAL     = 16,
    parameter int DEPTH        = 2
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           en,
    input  logic                           clr,
    input  logic [NUM_CH-1:0]              a,
    output logic [NUM_CH-1:0]              y,
    output logic [NUM_CH*COUNTER_SIZE-1:0] level,
    output logic [NUM_CH-1:0]              ovf
);

    logic [LFSR_BITS-1:0] r;

    fibonacci_lfsr_64 u_lfsr (
        .CLK  (CLK),
        .nRST (nRST),
        .r    (r)
    );

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
            localparam int ROT = rot_amt(i);
            localparam int LSB = level_lsb(i, COUNTER_SIZE);

            logic [LFSR_BITS-1:0]    r_rot;
            logic [COUNTER_SIZE-1:0] rnd;

            if (ROT == 0) begin : g_norot
                assign r_rot = r;
            end else begin : g_rot
                assign r_rot = {r[LFSR_BITS-1-ROT:0], r[LFSR_BITS-1:LFSR_BITS-ROT]};
            end
            assign rnd = r_rot[COUNTER_SIZE-1:0];

            stoch_decorr_lane #(
                .COUNTER_SIZE (COUNTER_SIZE),
                .STEP_VAL     (STEP_VAL),
                .DEPTH        (DEPTH)
            ) u_lane (
                .CLK   (CLK),
                .nRST  (nRST),
                .en    (en),
                .clr   (clr),
                .a     (a[i]),
                .rnd   (rnd),
                .y     (y[i]),
                .level (level[LSB +: COUNTER_SIZE]),
                .ovf   (ovf[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_stoch_decorr_array.sv
// Directed bench for stoch_decorr_array: two instances share all inputs.
// dut_m: NUM_CH=2, STEP_VAL=16, DEPTH=2.  dut_s: NUM_CH=2, STEP_VAL=128, DEPTH=8.
// Outputs sampled 1 time unit after the rising edge.
module tb_stoch_decorr_array;

    logic        CLK;
    logic        nRST;
    logic        en;
    logic        clr;
    logic [1:0]  a;

    logic [1:0]  y_m, ovf_m, y_s, ovf_s;
    logic [15:0] lvl_m, lvl_s;

    int n_cmp = 0;
    int n_err = 0;

    stoch_decorr_array #(
        .NUM_CH(2), .COUNTER_SIZE(8), .STEP_VAL(16), .DEPTH(2)
    ) dut_m (
        .CLK(CLK), .nRST(nRST), .en(en), .clr(clr), .a(a),
        .y(y_m), .level(lvl_m), .ovf(ovf_m)
    );

    stoch_decorr_array #(
        .NUM_CH(2), .COUNTER_SIZE(8), .STEP_VAL(128), .DEPTH(8)
    ) dut_s (
        .CLK(CLK), .nRST(nRST), .en(en), .clr(clr), .a(a),
        .y(y_s), .level(lvl_s), .ovf(ovf_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        a    = 2'b00;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        en   = 1'b1;
        clr  = 1'b0;
        a    = 2'b11;
        repeat (3) tick();
        nRST = 1'b1;
        en   = 1'b0;
        n_cmp++; if (y_m !== 2'b00)    begin n_err++; $display("FAIL reset_y_m got=%b exp=00", y_m); end
        n_cmp++; if (lvl_m !== 16'h0)  begin n_err++; $display("FAIL reset_lvl_m got=%h exp=0000", lvl_m); end
        n_cmp++; if (ovf_m !== 2'b00)  begin n_err++; $display("FAIL reset_ovf_m got=%b exp=00", ovf_m); end
        n_cmp++; if (y_s !== 2'b00)    begin n_err++; $display("FAIL reset_y_s got=%b exp=00", y_s); end
        n_cmp++; if (lvl_s !== 16'h0)  begin n_err++; $display("FAIL reset_lvl_s got=%h exp=0000", lvl_s); end
        // Released but not enabled: still all zero.
        repeat (2) tick();
        n_cmp++; if (lvl_m !== 16'h0 || y_m !== 2'b00 || ovf_m !== 2'b00)
            begin n_err++; $display("FAIL reset_hold_noen got lvl=%h y=%b ovf=%b exp 0/00/00", lvl_m, y_m, ovf_m); end
        // Reset mid-stream discards state.
        en = 1'b1;
        a  = 2'b11;
        repeat (5) tick();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        en   = 1'b0;
        n_cmp++; if (lvl_s !== 16'h0 || ovf_s !== 2'b00 || y_s !== 2'b00)
            begin n_err++; $display("FAIL reset_midstream got lvl=%h y=%b ovf=%b exp 0/00/00", lvl_s, y_s, ovf_s); end
        n_cmp++; if (lvl_m !== 16'h0 || ovf_m !== 2'b00 || y_m !== 2'b00)
            begin n_err++; $display("FAIL reset_midstream_m got lvl=%h y=%b ovf=%b exp 0/00/00", lvl_m, y_m, ovf_m); end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_lvl [3];
        logic [1:0]  exp_ovf [3];
        exp_lvl = '{16'h8080, 16'hFFFF, 16'hFFFF};
        exp_ovf = '{2'b00, 2'b11, 2'b11};
        do_reset();
        en = 1'b1;
        a  = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (lvl_s !== exp_lvl[k]) begin n_err++; $display("FAIL sat_level edge%0d got=%h exp=%h", k+1, lvl_s, exp_lvl[k]); end
            n_cmp++; if (ovf_s !== exp_ovf[k]) begin n_err++; $display("FAIL sat_ovf edge%0d got=%b exp=%b", k+1, ovf_s, exp_ovf[k]); end
            n_cmp++; if (y_s !== 2'b00)       begin n_err++; $display("FAIL sat_y edge%0d got=%b exp=00", k+1, y_s); end
        end
        a = 2'b00;
        for (int k = 3; k < 7; k++) begin
            tick();
            n_cmp++; if (y_s !== 2'b00) begin n_err++; $display("FAIL sat_y_delay edge%0d got=%b exp=00", k+1, y_s); end
        end
        n_cmp++; if (lvl_s !== 16'hFFFF) begin n_err++; $display("FAIL sat_level_hold got=%h exp=ffff", lvl_s); end
    endtask

    task automatic test_underflow();
        int bad_lvl = 0;
        do_reset();
        en = 1'b1;
        a  = 2'b00;
        for (int k = 0; k < 256; k++) begin
            tick();
            n_cmp++;
            if (lvl_m !== 16'h0 || ovf_m !== 2'b00) begin
                n_err++;
                if (bad_lvl < 4) $display("FAIL underflow cycle%0d got lvl=%h ovf=%b exp 0000/00", k, lvl_m, ovf_m);
                bad_lvl++;
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        en = 1'b1;
        a  = 2'b11;
        tick();
        a  = 2'b01;
        tick();
        n_cmp++; if (lvl_s !== 16'h80FF) begin n_err++; $display("FAIL clr_pre_level got=%h exp=80ff", lvl_s); end
        n_cmp++; if (ovf_s !== 2'b01)    begin n_err++; $display("FAIL clr_pre_ovf got=%b exp=01", ovf_s); end
        en  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (lvl_s !== 16'h0) begin n_err++; $display("FAIL clr_level got=%h exp=0000", lvl_s); end
        n_cmp++; if (ovf_s !== 2'b00) begin n_err++; $display("FAIL clr_ovf got=%b exp=00", ovf_s); end
        n_cmp++; if (y_s !== 2'b00)   begin n_err++; $display("FAIL clr_y got=%b exp=00", y_s); end
        // Clear also dominates en=1 with saturating input.
        en  = 1'b1;
        a   = 2'b11;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (lvl_s !== 16'h0 || ovf_s !== 2'b00)
            begin n_err++; $display("FAIL clr_over_en got lvl=%h ovf=%b exp 0000/00", lvl_s, ovf_s); end
    endtask

    task automatic test_stall();
        logic [1:0]  h_y, h_ovf, e_ovf;
        logic [15:0] h_lvl, e_lvl;
        logic [8:0]  s;
        logic [7:0]  c, l;
        int bad = 0;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            a = 2'($urandom_range(0, 3));
            tick();
        end
        h_y = y_m; h_lvl = lvl_m; h_ovf = ovf_m;
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            a = (k % 2 == 0) ? 2'b11 : 2'b00;
            tick();
            n_cmp++;
            if (y_m !== h_y || lvl_m !== h_lvl || ovf_m !== h_ovf) begin
                n_err++;
                if (bad < 4) $display("FAIL stall cycle%0d got y=%b lvl=%h ovf=%b exp y=%b lvl=%h ovf=%b",
                                      k, y_m, lvl_m, ovf_m, h_y, h_lvl, h_ovf);
                bad++;
            end
        end
        // Resume: next level follows from the held state and the new input.
        a = 2'b01;
        for (int i = 0; i < 2; i++) begin
            l = h_lvl[i*8 +: 8];
            s = {1'b0, l} + (a[i] ? 9'd16 : 9'd0);
            c = s[8] ? 8'hFF : s[7:0];
            e_ovf[i] = h_ovf[i] | s[8];
            if (h_y[i]) e_lvl[i*8 +: 8] = (c < 8'd16) ? 8'd0 : c - 8'd16;
            else        e_lvl[i*8 +: 8] = c;
        end
        en = 1'b1;
        tick();
        n_cmp++; if (lvl_m !== e_lvl) begin n_err++; $display("FAIL stall_resume_level got=%h exp=%h", lvl_m, e_lvl); end
        n_cmp++; if (ovf_m !== e_ovf) begin n_err++; $display("FAIL stall_resume_ovf got=%b exp=%b", ovf_m, e_ovf); end
    endtask

    task automatic test_statistics();
        int  ones0 = 0;
        int  ones1 = 0;
        int  diff  = 0;
        logic bit_a;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 4096; k++) begin
            bit_a = ($urandom_range(0, 3) == 0);
            a     = {bit_a, bit_a};
            tick();
            ones0 += int'(y_m[0]);
            ones1 += int'(y_m[1]);
            if (y_m[0] != y_m[1]) diff++;
        end
        n_cmp++; if (ones0 < 901 || ones0 > 1147) begin n_err++; $display("FAIL stats_ones0 got=%0d exp=1024+/-123", ones0); end
        n_cmp++; if (ones1 < 901 || ones1 > 1147) begin n_err++; $display("FAIL stats_ones1 got=%0d exp=1024+/-123", ones1); end
        n_cmp++; if (diff < 410) begin n_err++; $display("FAIL stats_decorr got=%0d exp>=410", diff); end
    endtask

    initial begin
        nRST = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        a    = 2'b00;
        test_reset();
        test_saturation();
        test_underflow();
        test_clear();
        test_stall();
        test_statistics();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
